// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit pipeline's memory-side blocks.
package cpu_pkg;

  localparam int WORD_W = 16;

  // Who owns the read data returning from memory next cycle.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_IF   = 2'd1,
    RESP_DM   = 2'd2
  } resp_owner_t;

  // Which requester wins a simultaneous request.
  typedef enum logic {
    PRI_DM = 1'b0,
    PRI_IF = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between fetch (IF) and the
// memory stage (DM). One grant per cycle, read data routed back to its
// owner two edges later, and a starvation guard so fetch always progresses.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = WORD_W,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  arb_state_t  state;
  resp_owner_t respOwner;
  logic [3:0]  starveCnt;
  logic [3:0]  starveNext;
  logic        ifReq;
  logic        dmReq;

  // Requests are masked while reset is held so the memory stays idle.
  assign ifReq = if_req & reset;
  assign dmReq = dm_req & reset;

  // IF wins when alone or when it holds priority; DM takes everything else.
  assign if_gnt = ifReq & (~dmReq | (state == PRI_IF));
  assign dm_gnt = dmReq & ~if_gnt;

  // Denied-cycle count for fetch, saturating rather than wrapping.
  always_comb begin
    starveNext = 4'd0;
    if (ifReq && !if_gnt)
      starveNext = (starveCnt == 4'hF) ? 4'hF : starveCnt + 4'd1;
  end

  // Memory port is driven by the winner; all zeros when idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_en   = 1'b1;
      mem_addr = if_addr;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  // Priority FSM and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= PRI_DM;
      starveCnt <= 4'd0;
    end else begin
      starveCnt <= starveNext;
      case (state)
        PRI_DM: if (starveNext >= MaxWait) state <= PRI_IF;
        PRI_IF: if (if_gnt) state <= PRI_DM;
        default: state <= PRI_DM;
      endcase
    end
  end

  // Remember who issued the read so its data can be steered next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               respOwner <= RESP_NONE;
    else if (if_gnt)          respOwner <= RESP_IF;
    else if (dm_gnt && !dm_we) respOwner <= RESP_DM;
    else                      respOwner <= RESP_NONE;
  end

  // Capture returning data into the owner's register; rvalid is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      if_rvalid <= (respOwner == RESP_IF);
      dm_rvalid <= (respOwner == RESP_DM);
      if (respOwner == RESP_IF) if_rdata <= mem_rdata;
      if (respOwner == RESP_DM) dm_rdata <= mem_rdata;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-port synchronous memory between instruction fetch (IF) and the memory stage (DM) of the 16-bit five-stage pipeline, so a unified instruction/data memory replaces separate instruction and data memories. It grants at most one access per cycle, routes one-cycle-latency read data back to the correct requester, and uses a starvation guard so fetch cannot be locked out by back-to-back data traffic. It sits between the Fetch/Memory stages and the memory macro. The pipeline uses the `*_gnt` outputs as its stall condition.

## Interface
- `ADDR_W`, default 16: memory word-address width.
- `DATA_W`, default 16: data width.
- `MAX_WAIT`, default 3: number of consecutive denied IF cycles (IF requesting, DM granted) after which IF gets priority. Legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch read request; held with `if_addr` stable until `if_gnt`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_gnt`  out  1  fetch request accepted this cycle (combinational).
- `if_rvalid`  out  1  `if_rdata` is valid; one-cycle pulse.
- `if_rdata`  out  DATA_W  fetched word; holds its value until the next IF response.
- `dm_req`  in  1  data request; held with address, data and `dm_we` stable until `dm_gnt`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  write data.
- `dm_gnt`  out  1  data request accepted this cycle (combinational).
- `dm_rvalid`  out  1  `dm_rdata` is valid; one-cycle pulse, reads only.
- `dm_rdata`  out  DATA_W  loaded word; holds its value until the next DM read response.
- `mem_en`, `mem_we`  out  1  memory enable and write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data, valid the cycle after `mem_en && !mem_we`.

## Operation
- Priority FSM states:
  - `PRI_DM` is the reset state. DM wins when both requesters are active.
  - `PRI_IF`: IF wins when both requesters are active.
- `starve_cnt` is a saturating counter, 4 bits wide.
  - Increments when `if_req && !if_gnt`.
  - Clears on `if_gnt` or when `!if_req`.
- FSM transitions:
  - `PRI_DM` → `PRI_IF` when the next-state value of `starve_cnt` is ≥ MAX_WAIT.
  - `PRI_IF` → `PRI_DM` on `if_gnt`.
- Grant rules:
  - Exactly one of `if_gnt` and `dm_gnt` is high when any request is present.
  - With a single requester, that requester is granted regardless of state.
- Memory drive:
  - On a grant: `mem_en` = 1, and `mem_addr`, `mem_we`, `mem_wdata` come from the winner. For an IF grant, `mem_we` = 0.
  - With no grant: `mem_en` = 0, `mem_we` = 0, and `mem_addr`/`mem_wdata` are 0.
- Response tracking: register `resp_owner` ∈ {NONE, IF, DM} is set on the granting edge to the read owner, and to NONE for a write or for no grant.
  - `resp_owner == IF`: `if_rvalid` = 1 and `if_rdata` ← `mem_rdata`.
  - `resp_owner == DM`: `dm_rvalid` = 1 and `dm_rdata` ← `mem_rdata`.
- `if_rdata` and `dm_rdata` are registered capture registers. They are loaded at the response edge and are not combinational pass-throughs.
- Writes produce no `rvalid`. `dm_gnt` is the write acknowledge.

## Timing
- Read latency is 2 edges:
  - Request and grant in cycle N.
  - Memory samples at edge N.
  - Data on `mem_rdata` in cycle N+1.
  - Captured at edge N+1, so `rvalid` and `rdata` are visible in cycle N+2.
  - A new grant may issue in cycle N+1, giving full throughput of one access per cycle.
- Reset values: FSM = `PRI_DM`, `starve_cnt` = 0, `resp_owner` = NONE, `if_rvalid` = `dm_rvalid` = 0, `if_rdata` = `dm_rdata` = 0. `mem_en` = 0 follows because requests are gated while `reset` = 0.
- Reset mid-read: the in-flight response is discarded and no `rvalid` is produced after reset releases.
- Simultaneous `rvalid` for both requesters is impossible, because only one grant is issued per cycle.
- `starve_cnt` saturates at 15 and never wraps.

## Structure
- Shared package `cpu_pkg`:
  - `resp_owner_t` enum (NONE, IF, DM).
  - `arb_state_t` enum (PRI_DM, PRI_IF).
  - `WORD_W` = 16 constant.
- No sub-module is needed. This is one module containing the FSM, the counter, the response register and the capture registers.

## Test plan
- Single IF read, addr 0x0010, memory model returns 0xA5A5: `if_gnt` in cycle 0; `if_rvalid` = 1 and `if_rdata` = 0xA5A5 in cycle 2; `dm_rvalid` stays 0.
- DM write addr 0x0040, data 0x1234, then DM read of 0x0040: write cycle shows `mem_we` = 1 and `mem_wdata` = 0x1234 with no `rvalid`; the read returns `dm_rdata` = 0x1234.
- IF and DM both requesting continuously, MAX_WAIT = 3: grant sequence is DM, DM, DM, IF, DM, DM, DM, IF, … and IF is never denied more than 3 consecutive cycles.
- Back-to-back reads IF@0x2, DM@0x8, IF@0x4: three consecutive `mem_en` cycles, each `rvalid` pulse routed to the correct owner with the correct data, and each `rdata` holding between its pulses.
- Assert `reset` = 0 in the cycle after an IF grant: no `if_rvalid` appears afterward, all outputs are at reset values, and the first post-reset request sees priority `PRI_DM`.
- Idle, no requests: `mem_en` = 0 and `starve_cnt` = 0. Then `if_req` alone arriving while the FSM is in `PRI_DM` is granted in the same cycle.
